// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised adding-machine CPU: opcode
// encoding, opcode field width and FSM state encoding.
package cpu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_JMP = 3'b010,
    OP_STA = 3'b011,
    OP_LDA = 3'b100,
    OP_SUB = 3'b101,
    OP_JZ  = 3'b110,
    OP_HLT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC_RD = 3'd2,
    S_EXEC_WR = 3'd3,
    S_HALT    = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_ctrl.sv
// Control FSM: sequences fetch/decode/execute, stretches every bus access
// until mem_ready, and emits register enables plus bus requests.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    mem_ready,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    ir_load,
  output logic    pc_inc,
  output logic    pc_load,
  output logic    ac_load,
  output logic    use_ir_adr,
  output logic    rd_req,
  output logic    wr_req,
  output logic    halted
);

  state_t state;

  // State register; HALT is left only through reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_AND, OP_LDA, OP_SUB: state <= S_EXEC_RD;
            OP_STA:                         state <= S_EXEC_WR;
            OP_HLT:                         state <= S_HALT;
            default:                        state <= S_FETCH;
          endcase
        end
        S_EXEC_RD: if (mem_ready) state <= S_FETCH;
        S_EXEC_WR: if (mem_ready) state <= S_FETCH;
        S_HALT:    state <= S_HALT;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Enables and requests decoded straight from the state flops; requests
  // are masked by rst so an in-flight access drops without waiting for clk.
  // NOTE: every output is assigned on every path, so no latch is inferred.
  always_comb begin
    ir_load    = (state == S_FETCH) && mem_ready;
    pc_inc     = (state == S_FETCH) && mem_ready;
    pc_load    = (state == S_DECODE) &&
                 ((opcode == OP_JMP) || ((opcode == OP_JZ) && zero));
    ac_load    = (state == S_EXEC_RD) && mem_ready;
    use_ir_adr = (state == S_EXEC_RD) || (state == S_EXEC_WR);
    rd_req     = !rst && ((state == S_FETCH) || (state == S_EXEC_RD));
    wr_req     = !rst && (state == S_EXEC_WR);
    halted     = (state == S_HALT);
  end

endmodule

// File: rtl/param_adding_cpu.sv
// Single-accumulator CPU with generic data width: PC/IR/AC/Z/C registers,
// the ALU and the address bus mux. Sequencing lives in cpu_ctrl.
module param_adding_cpu
  import cpu_pkg::*;
#(
  parameter  int DATA_W = 9,
  localparam int ADR_W  = DATA_W - OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_bus_in,
  input  logic              mem_ready,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [ADR_W-1:0]  adr_bus,
  output logic [DATA_W-1:0] data_bus_out,
  output logic              halted,
  output logic              zero_flag,
  output logic              carry_flag
);

  logic [ADR_W-1:0]  pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              ir_load, pc_inc, pc_load, ac_load, use_ir_adr;
  opcode_t           opcode;

  assign opcode = opcode_t'(ir[DATA_W-1 -: OP_W]);

  cpu_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .mem_ready  (mem_ready),
    .opcode     (opcode),
    .zero       (zero_flag),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .ac_load    (ac_load),
    .use_ir_adr (use_ir_adr),
    .rd_req     (rd_mem),
    .wr_req     (wr_mem),
    .halted     (halted)
  );

  // One extra bit catches the carry out of the modulo-2^DATA_W add.
  assign sum = {1'b0, ac} + {1'b0, data_bus_in};

  // ALU result for the memory-operand instructions; carry holds unless the
  // instruction defines it.
  always_comb begin
    alu_res   = ac;
    alu_carry = carry_flag;
    case (opcode)
      OP_ADD: begin
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_AND: alu_res = ac & data_bus_in;
      OP_LDA: alu_res = data_bus_in;
      OP_SUB: begin
        alu_res   = ac - data_bus_in;
        alu_carry = (ac >= data_bus_in);
      end
      default: ;
    endcase
  end

  // Architectural registers; PC increment (FETCH) and jump (DECODE) are
  // mutually exclusive in time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      ac         <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      if (pc_load)     pc <= ir[ADR_W-1:0];
      else if (pc_inc) pc <= pc + 1'b1;
      if (ir_load) ir <= data_bus_in;
      if (ac_load) begin
        ac         <= alu_res;
        zero_flag  <= (alu_res == '0);
        carry_flag <= alu_carry;
      end
    end
  end

  assign adr_bus      = use_ir_adr ? ir[ADR_W-1:0] : pc;
  assign data_bus_out = ac;

endmodule

// File: tb/tb_param_adding_cpu.sv
// Self-checking bench for param_adding_cpu (DATA_W=9): a behavioural
// memory with controllable mem_ready, and a scoreboard of expected writes.
module tb_param_adding_cpu;
  import cpu_pkg::*;

  localparam int DW = 9;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_ready = 1'b1;
  logic [DW-1:0] data_bus_in, data_bus_out;
  logic          rd_mem, wr_mem, halted, zero_flag, carry_flag;
  logic [AW-1:0] adr_bus;

  logic [DW-1:0] mem [64];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp_w;

  param_adding_cpu #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_bus_in  (data_bus_in),
    .mem_ready    (mem_ready),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .adr_bus      (adr_bus),
    .data_bus_out (data_bus_out),
    .halted       (halted),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag)
  );

  always #5 clk = ~clk;

  assign data_bus_in = mem[adr_bus];

  // Memory write port and write scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && rd_mem && wr_mem) begin
      miscompares++;
      $display("FAIL bus_exclusive: rd_mem and wr_mem both high at adr %0d", adr_bus);
    end
    if (!rst && wr_mem && mem_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got adr=%0d data=%0d, expected no write", adr_bus, data_bus_out);
      end else begin
        exp_w = exp_q.pop_front();
        if (adr_bus !== exp_w.adr || data_bus_out !== exp_w.data) begin
          miscompares++;
          $display("FAIL write: got adr=%0d data=%0d, expected adr=%0d data=%0d",
                   adr_bus, data_bus_out, exp_w.adr, exp_w.data);
        end
      end
      mem[adr_bus] = data_bus_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk(opcode_t op, int a);
    logic [AW-1:0] av;
    av = AW'(a);
    return {op, av};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = mk(OP_HLT, 0);
    exp_q.delete();
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.adr  = AW'(a);
    w.data = DW'(d);
    exp_q.push_back(w);
  endtask

  // Reset released on a falling edge; the next rising edge is cycle 1.
  task automatic apply_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_halt(input int max, output int n);
    n = 0;
    while (!halted && n < max) begin
      step(1);
      n++;
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_writes_pending: %0d expected writes never seen, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({rd_mem, wr_mem, halted} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_requests: rd/wr/halted=%b, expected 000", {rd_mem, wr_mem, halted});
    end
    vectors++;
    if ({zero_flag, carry_flag} !== 2'b00 || data_bus_out !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: z=%b c=%b ac=%0d, expected z=0 c=0 ac=0", zero_flag, carry_flag, data_bus_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (rd_mem !== 1'b1 || adr_bus !== '0) begin
      miscompares++;
      $display("FAIL reset_first_fetch: rd=%b adr=%0d, expected rd=1 adr=0", rd_mem, adr_bus);
    end
  endtask

  task automatic test_program();
    int n;
    clear_mem();
    mem[0] = mk(OP_LDA, 10); mem[1] = mk(OP_ADD, 11);
    mem[2] = mk(OP_STA, 12); mem[3] = mk(OP_HLT, 0);
    mem[10] = DW'(100); mem[11] = DW'(55);
    push_wr(12, 155);
    apply_reset();
    run_to_halt(60, n);
    vectors++;
    if (n !== 11 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL program_halt_cycles: got %0d (halted=%b), expected 11", n, halted);
    end
    vectors++;
    if (data_bus_out !== DW'(155)) begin
      miscompares++;
      $display("FAIL program_ac: got %0d, expected 155", data_bus_out);
    end
    check_drained("program");
  endtask

  task automatic test_add_overflow();
    int n;
    clear_mem();
    mem[0] = mk(OP_LDA, 10); mem[1] = mk(OP_ADD, 11); mem[2] = mk(OP_STA, 12);
    mem[10] = DW'(500); mem[11] = DW'(20);
    push_wr(12, 8);
    apply_reset();
    run_to_halt(60, n);
    vectors++;
    if (data_bus_out !== DW'(8) || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL add_overflow: ac=%0d c=%b z=%b, expected ac=8 c=1 z=0", data_bus_out, carry_flag, zero_flag);
    end
    check_drained("add_overflow");
  endtask

  task automatic test_sub_jz();
    int n;
    clear_mem();
    mem[0] = mk(OP_LDA, 10); mem[1] = mk(OP_SUB, 11); mem[2] = mk(OP_JZ, 40);
    mem[40] = mk(OP_STA, 12);
    mem[10] = DW'(7); mem[11] = DW'(7);
    push_wr(12, 0);
    apply_reset();
    step(8);
    vectors++;
    if (data_bus_out !== '0 || zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_flags: ac=%0d z=%b c=%b, expected ac=0 z=1 c=1", data_bus_out, zero_flag, carry_flag);
    end
    vectors++;
    if (rd_mem !== 1'b1 || adr_bus !== AW'(40)) begin
      miscompares++;
      $display("FAIL jz_taken_fetch: rd=%b adr=%0d, expected rd=1 adr=40", rd_mem, adr_bus);
    end
    run_to_halt(40, n);
    check_drained("sub_jz");
  endtask

  task automatic test_wait_states();
    logic pat [8];
    logic [DW-1:0] exp_ac;
    int n;
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    clear_mem();
    mem[0] = mk(OP_LDA, 10); mem[1] = mk(OP_ADD, 11);
    mem[10] = DW'(3); mem[11] = DW'(4);
    apply_reset();
    step(3);
    for (int i = 0; i < 8; i++) begin
      mem_ready = pat[i];
      step(1);
      exp_ac = (i == 7) ? DW'(7) : DW'(3);
      vectors++;
      if (data_bus_out !== exp_ac) begin
        miscompares++;
        $display("FAIL wait_ac cycle %0d: got %0d, expected %0d", i, data_bus_out, exp_ac);
      end
      if (i == 1 || i == 5) begin
        vectors++;
        if (rd_mem !== 1'b1 || adr_bus !== ((i == 1) ? AW'(1) : AW'(11))) begin
          miscompares++;
          $display("FAIL wait_hold cycle %0d: rd=%b adr=%0d, expected rd=1 adr=%0d",
                   i, rd_mem, adr_bus, (i == 1) ? 1 : 11);
        end
      end
    end
    mem_ready = 1'b1;
    vectors++;
    if (rd_mem !== 1'b1 || adr_bus !== AW'(2)) begin
      miscompares++;
      $display("FAIL wait_next_fetch: rd=%b adr=%0d, expected rd=1 adr=2", rd_mem, adr_bus);
    end
    run_to_halt(40, n);
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0] = mk(OP_LDA, 10); mem[1] = mk(OP_JMP, 63); mem[63] = mk(OP_AND, 5);
    mem[10] = 9'h0F3; mem[5] = 9'h13C;
    apply_reset();
    step(8);
    vectors++;
    if (rd_mem !== 1'b1 || adr_bus !== '0) begin
      miscompares++;
      $display("FAIL pc_wrap_fetch: rd=%b adr=%0d, expected rd=1 adr=0", rd_mem, adr_bus);
    end
    vectors++;
    if (data_bus_out !== 9'h030 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL and_result: ac=%0h z=%b c=%b, expected ac=30 z=0 c=0", data_bus_out, zero_flag, carry_flag);
    end
  endtask

  task automatic test_reset_mid_write();
    clear_mem();
    mem[0] = mk(OP_LDA, 10); mem[1] = mk(OP_STA, 12);
    mem[10] = DW'(42); mem[12] = 9'h055;
    apply_reset();
    step(4);
    mem_ready = 1'b0;
    step(1);
    vectors++;
    if (wr_mem !== 1'b1 || rd_mem !== 1'b0 || adr_bus !== AW'(12) || data_bus_out !== DW'(42)) begin
      miscompares++;
      $display("FAIL exec_wr_bus: wr=%b rd=%b adr=%0d data=%0d, expected wr=1 rd=0 adr=12 data=42",
               wr_mem, rd_mem, adr_bus, data_bus_out);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (wr_mem !== 1'b0 || rd_mem !== 1'b0 || data_bus_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_write: wr=%b rd=%b ac=%0d, expected wr=0 rd=0 ac=0", wr_mem, rd_mem, data_bus_out);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (rd_mem !== 1'b1 || adr_bus !== '0 || data_bus_out !== '0) begin
      miscompares++;
      $display("FAIL post_reset_fetch: rd=%b adr=%0d ac=%0d, expected rd=1 adr=0 ac=0", rd_mem, adr_bus, data_bus_out);
    end
    vectors++;
    if (mem[12] !== 9'h055) begin
      miscompares++;
      $display("FAIL aborted_write: mem[12]=%0h, expected 55", mem[12]);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_program();
    test_add_overflow();
    test_sub_jz();
    test_wait_states();
    test_pc_wrap();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
